// File: rtl/axi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_arbiter
// Description : Two-master (fetch / data) round-robin arbiter that sequences
//               single-beat transactions onto the shared RAM's simplified
//               AXI channels, keeping exactly one transaction outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  // fetch port (read only)
  input  logic                io_if_req,
  input  logic [ADDR_W-1:0]   io_if_addr,
  output logic                io_if_acc,
  output logic                io_if_rvalid,
  output logic [DATA_W-1:0]   io_if_rdata,
  // data port (read / write)
  input  logic                io_d_req,
  input  logic                io_d_wen,
  input  logic [ADDR_W-1:0]   io_d_addr,
  input  logic [DATA_W-1:0]   io_d_wdata,
  input  logic [DATA_W/8-1:0] io_d_wstrb,
  output logic                io_d_acc,
  output logic                io_d_rvalid,
  output logic [DATA_W-1:0]   io_d_rdata,
  // RAM read channels
  output logic [ADDR_W-1:0]   io_ram_araddr,
  output logic                io_ram_arvalid,
  input  logic                io_ram_arready,
  input  logic [DATA_W-1:0]   io_ram_rdata,
  // RAM write channels
  output logic [ADDR_W-1:0]   io_ram_awaddr,
  output logic                io_ram_awvalid,
  input  logic                io_ram_awready,
  output logic [DATA_W-1:0]   io_ram_wdata,
  output logic [DATA_W/8-1:0] io_ram_wstrb,
  output logic                io_ram_wvalid,
  input  logic                io_ram_wready,
  input  logic                io_ram_bvalid,
  // status
  output logic                io_busy
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_prio_d;    // 1: data wins a simultaneous request
  logic                r_owner_d;   // 1: current transaction belongs to data
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_d_ack;     // write acknowledge, one cycle after bvalid
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;

  logic                w_grant_d;
  logic                w_grant_if;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic                w_wr_sent;
  logic                w_rd_resp_if;
  logic                w_rd_resp_d;

  assign io_ram_arvalid = (r_state == RD_ADDR);
  assign io_ram_awvalid = (r_state == WR_REQ) && !r_aw_done;
  assign io_ram_wvalid  = (r_state == WR_REQ) && !r_w_done;
  assign io_ram_araddr  = r_addr;
  assign io_ram_awaddr  = r_addr;
  assign io_ram_wdata   = r_wdata;
  assign io_ram_wstrb   = r_wstrb;

  assign w_aw_fire    = io_ram_awvalid && io_ram_awready;
  assign w_w_fire     = io_ram_wvalid && io_ram_wready;
  assign w_wr_sent    = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);
  assign w_rd_resp_if = (r_state == RD_DATA) && !r_owner_d;
  assign w_rd_resp_d  = (r_state == RD_DATA) && r_owner_d;

  // Read data is forwarded straight from the RAM on the response cycle and
  // held in a register afterwards so the outputs keep their last value.
  assign io_if_acc    = w_grant_if;
  assign io_d_acc     = w_grant_d;
  assign io_if_rvalid = w_rd_resp_if;
  assign io_d_rvalid  = w_rd_resp_d || r_d_ack;
  assign io_if_rdata  = w_rd_resp_if ? io_ram_rdata : r_if_rdata;
  assign io_d_rdata   = w_rd_resp_d ? io_ram_rdata : r_d_rdata;
  assign io_busy      = (r_state != IDLE);

  // Grant decision and next-state logic; no grant during a write-ack cycle
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_d_ack) begin
          if (io_d_req && (!io_if_req || r_prio_d)) begin
            w_grant_d   = 1'b1;
            w_state_nxt = io_d_wen ? WR_REQ : RD_ADDR;
          end else if (io_if_req) begin
            w_grant_if  = 1'b1;
            w_state_nxt = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (io_ram_arready) begin
          w_state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        w_state_nxt = IDLE;
      end
      WR_REQ: begin
        if (w_wr_sent) begin
          w_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (io_ram_bvalid) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latching, priority pointer, channel done flags and response data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prio_d   <= 1'b1;
      r_owner_d  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_d_ack <= 1'b0;
      if (w_grant_d) begin
        r_owner_d <= 1'b1;
        r_prio_d  <= 1'b0;
        r_addr    <= io_d_addr;
        r_wdata   <= io_d_wdata;
        r_wstrb   <= io_d_wstrb;
      end else if (w_grant_if) begin
        r_owner_d <= 1'b0;
        r_prio_d  <= 1'b1;
        r_addr    <= io_if_addr;
      end
      if ((r_state == WR_REQ) && !w_wr_sent) begin
        r_aw_done <= r_aw_done || w_aw_fire;
        r_w_done  <= r_w_done || w_w_fire;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_rd_resp_if) begin
        r_if_rdata <= io_ram_rdata;
      end
      if (w_rd_resp_d) begin
        r_d_rdata <= io_ram_rdata;
      end
      if ((r_state == WR_RESP) && io_ram_bvalid) begin
        r_d_ack   <= 1'b1;
        r_d_rdata <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_ram_arbiter
// Description : Directed self-checking bench for axi_ram_arbiter with a small
//               RAM responder and a response scoreboard per master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_if_req;
  logic [ADDR_W-1:0] io_if_addr;
  logic              io_if_acc;
  logic              io_if_rvalid;
  logic [DATA_W-1:0] io_if_rdata;
  logic              io_d_req;
  logic              io_d_wen;
  logic [ADDR_W-1:0] io_d_addr;
  logic [DATA_W-1:0] io_d_wdata;
  logic [STRB_W-1:0] io_d_wstrb;
  logic              io_d_acc;
  logic              io_d_rvalid;
  logic [DATA_W-1:0] io_d_rdata;
  logic [ADDR_W-1:0] io_ram_araddr;
  logic              io_ram_arvalid;
  logic              io_ram_arready;
  logic [DATA_W-1:0] io_ram_rdata = '0;
  logic [ADDR_W-1:0] io_ram_awaddr;
  logic              io_ram_awvalid;
  logic              io_ram_awready;
  logic [DATA_W-1:0] io_ram_wdata;
  logic [STRB_W-1:0] io_ram_wstrb;
  logic              io_ram_wvalid;
  logic              io_ram_wready;
  logic              io_ram_bvalid;
  logic              io_busy;

  always #5 clock = ~clock;

  axi_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_if_req      (io_if_req),
    .io_if_addr     (io_if_addr),
    .io_if_acc      (io_if_acc),
    .io_if_rvalid   (io_if_rvalid),
    .io_if_rdata    (io_if_rdata),
    .io_d_req       (io_d_req),
    .io_d_wen       (io_d_wen),
    .io_d_addr      (io_d_addr),
    .io_d_wdata     (io_d_wdata),
    .io_d_wstrb     (io_d_wstrb),
    .io_d_acc       (io_d_acc),
    .io_d_rvalid    (io_d_rvalid),
    .io_d_rdata     (io_d_rdata),
    .io_ram_araddr  (io_ram_araddr),
    .io_ram_arvalid (io_ram_arvalid),
    .io_ram_arready (io_ram_arready),
    .io_ram_rdata   (io_ram_rdata),
    .io_ram_awaddr  (io_ram_awaddr),
    .io_ram_awvalid (io_ram_awvalid),
    .io_ram_awready (io_ram_awready),
    .io_ram_wdata   (io_ram_wdata),
    .io_ram_wstrb   (io_ram_wstrb),
    .io_ram_wvalid  (io_ram_wvalid),
    .io_ram_wready  (io_ram_wready),
    .io_ram_bvalid  (io_ram_bvalid),
    .io_busy        (io_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] q_if[$];
  logic [DATA_W-1:0] q_d[$];

  // RAM contents as seen by the bench
  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM responder: programmable ready stalls, rdata one cycle after AR,
  // bvalid one cycle after both AW and W have completed
  int   ar_stall = 0, aw_stall = 0, w_stall = 0;
  int   ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic b_auto = 1'b1, b_inject = 1'b0, r_b_pulse = 1'b0;
  logic aw_got = 1'b0, w_got = 1'b0;
  logic aw_hs, w_hs;

  assign io_ram_arready = (ar_wait >= ar_stall);
  assign io_ram_awready = (aw_wait >= aw_stall);
  assign io_ram_wready  = (w_wait >= w_stall);
  assign io_ram_bvalid  = r_b_pulse | b_inject;
  assign aw_hs = io_ram_awvalid && io_ram_awready;
  assign w_hs  = io_ram_wvalid && io_ram_wready;

  always @(posedge clock) begin
    if (reset) begin
      ar_wait   <= 0;
      aw_wait   <= 0;
      w_wait    <= 0;
      r_b_pulse <= 1'b0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
    end else begin
      ar_wait   <= (io_ram_arvalid && !io_ram_arready) ? ar_wait + 1 : 0;
      aw_wait   <= (io_ram_awvalid && !io_ram_awready) ? aw_wait + 1 : 0;
      w_wait    <= (io_ram_wvalid && !io_ram_wready) ? w_wait + 1 : 0;
      if (io_ram_arvalid && io_ram_arready) io_ram_rdata <= mem_val(io_ram_araddr);
      r_b_pulse <= 1'b0;
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got    <= 1'b0;
        w_got     <= 1'b0;
        r_b_pulse <= b_auto;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rvalid pulse
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      chk("excl_acc", {63'd0, io_if_acc & io_d_acc}, 64'd0);
      chk("excl_rvalid", {63'd0, io_if_rvalid & io_d_rvalid}, 64'd0);
      if (io_if_rvalid) begin
        if (q_if.size() == 0) chk("if_unexpected_rvalid", {63'd0, io_if_rvalid}, 64'd0);
        else chk("if_rdata", io_if_rdata, q_if.pop_front());
      end
      if (io_d_rvalid) begin
        if (q_d.size() == 0) chk("d_unexpected_rvalid", {63'd0, io_d_rvalid}, 64'd0);
        else chk("d_rdata", io_d_rdata, q_d.pop_front());
      end
    end
  end

  task automatic drain(input string tag);
    int k = 0;
    while ((q_if.size() != 0 || q_d.size() != 0 || io_busy) && k < 40) begin
      @(negedge clock);
      #3;
      k++;
    end
    chk({tag, "_drained"}, 64'(q_if.size() + q_d.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]        seq;
    int                n, cyc, first_d, first_if;
    logic              bump_d, bump_if;
    int                aw_cnt, w_cnt, rv_cnt, bcyc, rvcyc, arv_cnt, if_acc_c;
    logic              addr_ok, busy_ok;
    logic [DATA_W-1:0] wd;
    logic [STRB_W-1:0] ws;

    reset = 1'b1;
    io_if_req = 1'b0; io_if_addr = '0;
    io_d_req = 1'b0; io_d_wen = 1'b0; io_d_addr = '0; io_d_wdata = '0; io_d_wstrb = '0;

    // ---- reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", io_busy, 0);
    chk("rst_acc", {io_if_acc, io_d_acc}, 0);
    chk("rst_rvalid", {io_if_rvalid, io_d_rvalid}, 0);
    chk("rst_ram_valid", {io_ram_arvalid, io_ram_awvalid, io_ram_wvalid}, 0);
    chk("rst_if_rdata", io_if_rdata, 0);
    chk("rst_d_rdata", io_d_rdata, 0);
    reset = 1'b0;

    // ---- fetch read alone, zero-wait RAM
    @(negedge clock);
    io_if_req = 1'b1; io_if_addr = 32'h8000_0000;
    #1;
    chk("t1_if_acc", io_if_acc, 1);
    chk("t1_d_acc", io_d_acc, 0);
    q_if.push_back(64'h1122_3344_5566_7788);
    @(negedge clock);
    io_if_req = 1'b0;
    #1;
    chk("t1_arvalid", io_ram_arvalid, 1);
    chk("t1_araddr", io_ram_araddr, 32'h8000_0000);
    chk("t1_rvalid_early", io_if_rvalid, 0);
    @(negedge clock);
    #1;
    chk("t1_if_rvalid", io_if_rvalid, 1);
    chk("t1_if_rdata_now", io_if_rdata, 64'h1122_3344_5566_7788);
    chk("t1_d_silent", {io_d_acc, io_d_rvalid}, 0);
    @(negedge clock);
    #1;
    chk("t1_rdata_hold", io_if_rdata, 64'h1122_3344_5566_7788);
    chk("t1_idle", io_busy, 0);
    drain("t1");

    // ---- both request after reset: data first, then alternate
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    io_d_req = 1'b1; io_d_wen = 1'b0; io_d_addr = 32'h8000_0100;
    io_if_req = 1'b1; io_if_addr = 32'h8000_0200;
    #1;
    seq = 4'b1111; n = 0; cyc = 0; first_d = -1; first_if = -1;
    bump_d = 1'b0; bump_if = 1'b0;
    while (n < 4 && cyc < 60) begin
      if (io_d_acc) begin
        q_d.push_back(mem_val(io_d_addr));
        seq[n] = 1'b1;
        if (first_d < 0) first_d = cyc;
        n++;
        bump_d = 1'b1;
      end else if (io_if_acc) begin
        q_if.push_back(mem_val(io_if_addr));
        seq[n] = 1'b0;
        if (first_if < 0) first_if = cyc;
        n++;
        bump_if = 1'b1;
      end
      @(negedge clock);
      cyc++;
      if (bump_d)  io_d_addr  = io_d_addr + 32'd8;
      if (bump_if) io_if_addr = io_if_addr + 32'd8;
      bump_d = 1'b0; bump_if = 1'b0;
      #1;
    end
    io_d_req = 1'b0; io_if_req = 1'b0;
    chk("t2_grants", 64'(n), 64'd4);
    chk("t2_order", seq, 4'b0101);
    chk("t2_first_d", 64'(first_d), 64'd0);
    chk("t2_first_if", 64'(first_if), 64'd3);
    drain("t2");

    // ---- data write with awready stalled two cycles
    aw_stall = 2;
    @(negedge clock);
    io_d_req = 1'b1; io_d_wen = 1'b1; io_d_addr = 32'h8000_1000;
    io_d_wdata = 64'h0000_0000_DEAD_BEEF; io_d_wstrb = 8'h0F;
    #1;
    chk("t3_d_acc", io_d_acc, 1);
    q_d.push_back(64'h0);
    aw_cnt = 0; w_cnt = 0; rv_cnt = 0; bcyc = -1; rvcyc = -1; addr_ok = 1'b1;
    wd = '0; ws = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) io_d_req = 1'b0;
      #1;
      if (io_ram_awvalid) begin
        aw_cnt++;
        if (io_ram_awaddr !== 32'h8000_1000) addr_ok = 1'b0;
      end
      if (io_ram_wvalid) begin
        w_cnt++;
        wd = io_ram_wdata;
        ws = io_ram_wstrb;
      end
      if (io_ram_bvalid && bcyc < 0) bcyc = c;
      if (io_d_rvalid) begin
        rv_cnt++;
        if (rvcyc < 0) rvcyc = c;
      end
    end
    aw_stall = 0;
    chk("t3_awvalid_cycles", 64'(aw_cnt), 64'd3);
    chk("t3_wvalid_cycles", 64'(w_cnt), 64'd1);
    chk("t3_awaddr", addr_ok, 1);
    chk("t3_wdata", wd, 64'h0000_0000_DEAD_BEEF);
    chk("t3_wstrb", ws, 8'h0F);
    chk("t3_ack_count", 64'(rv_cnt), 64'd1);
    chk("t3_ack_cycle", 64'(rvcyc), 64'd5);
    chk("t3_ack_after_b", 64'(rvcyc - bcyc), 64'd1);
    drain("t3");

    // ---- arready stalled five cycles with a fetch waiting
    ar_stall = 5;
    @(negedge clock);
    io_d_req = 1'b1; io_d_wen = 1'b0; io_d_addr = 32'h8000_2000;
    #1;
    chk("t4_d_acc", io_d_acc, 1);
    q_d.push_back(mem_val(32'h8000_2000));
    arv_cnt = 0; addr_ok = 1'b1; busy_ok = 1'b1; if_acc_c = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin
        io_d_req = 1'b0;
        io_if_req = 1'b1; io_if_addr = 32'h8000_3000;
      end
      #1;
      if (io_ram_arvalid) begin
        arv_cnt++;
        if (io_ram_araddr !== 32'h8000_2000) addr_ok = 1'b0;
        if (!io_busy) busy_ok = 1'b0;
      end
      if (io_if_acc && if_acc_c < 0) begin
        if_acc_c = c;
        q_if.push_back(mem_val(io_if_addr));
      end
    end
    @(negedge clock);
    io_if_req = 1'b0;
    ar_stall = 0;
    chk("t4_arvalid_cycles", 64'(arv_cnt), 64'd6);
    chk("t4_araddr_stable", addr_ok, 1);
    chk("t4_busy", busy_ok, 1);
    chk("t4_if_acc_cycle", 64'(if_acc_c), 64'd8);
    drain("t4");

    // ---- reset while waiting for bvalid aborts the write
    b_auto = 1'b0;
    @(negedge clock);
    io_d_req = 1'b1; io_d_wen = 1'b1; io_d_addr = 32'h8000_4000;
    io_d_wdata = 64'h5555_AAAA_5555_AAAA; io_d_wstrb = 8'hFF;
    #1;
    chk("t5_d_acc", io_d_acc, 1);
    @(negedge clock);
    io_d_req = 1'b0;
    @(negedge clock);
    #1;
    chk("t5_wr_resp_busy", io_busy, 1);
    chk("t5_wr_resp_valids", {io_ram_awvalid, io_ram_wvalid}, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", io_busy, 0);
    chk("t5_rst_if_rdata", io_if_rdata, 0);
    chk("t5_rst_d_rdata", io_d_rdata, 0);
    chk("t5_rst_flags", {io_if_acc, io_d_acc, io_if_rvalid, io_d_rvalid,
                         io_ram_arvalid, io_ram_awvalid, io_ram_wvalid}, 0);
    b_auto = 1'b1;
    b_inject = 1'b1;
    rv_cnt = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      b_inject = 1'b0;
      #1;
      if (io_d_rvalid) rv_cnt++;
      if (io_busy) busy_ok = 1'b0;
    end
    chk("t5_no_late_ack", 64'(rv_cnt), 64'd0);
    chk("t5_stays_idle", busy_ok, 1);

    // ---- spurious bvalid while idle, then a normal fetch
    @(negedge clock);
    b_inject = 1'b1;
    #1;
    chk("t6_spurious_rvalid", {io_if_rvalid, io_d_rvalid}, 0);
    @(negedge clock);
    b_inject = 1'b0;
    #1;
    chk("t6_idle", io_busy, 0);
    chk("t6_no_ack", io_d_rvalid, 0);
    io_if_req = 1'b1; io_if_addr = 32'h8000_5000;
    #1;
    chk("t6_if_acc", io_if_acc, 1);
    q_if.push_back(mem_val(32'h8000_5000));
    @(negedge clock);
    io_if_req = 1'b0;
    @(negedge clock);
    #1;
    chk("t6_if_rvalid", io_if_rvalid, 1);
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
